// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states, FIFO entry and the parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the PS/2 clock and data lines into i_clk and flags falling edges of the PS/2 clock.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_pulse_o,
  output logic data_sync_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Lines idle high, so reset fills the chains with ones to avoid a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_pulse_o = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_sync_o  = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: frame FSM with watchdog, F0 break-prefix tracking and a small scancode FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames whose parity bit does not give odd parity.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd100000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_code,
  output logic       o_break,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic fall_pulse;
  logic data_sync;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .ps2_clk_i    (i_ps2_clk),
    .ps2_data_i   (i_ps2_data),
    .fall_pulse_o (fall_pulse),
    .data_sync_o  (data_sync)
  );

  ps2_state_e  state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        parity_ok_q;
  logic        break_pend_q;
  logic [31:0] wdog_q;
  logic        frame_err_q;
  logic        overflow_q;

  logic        frame_ok;
  logic        frame_bad;
  logic        timeout;
  logic        push_en;
  ps2_entry_t  push_entry;

  ps2_entry_t  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_acc;
  logic        drop;
  ps2_entry_t  head;

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    if (state_q != ST_IDLE && !fall_pulse && wdog_q >= TIMEOUT - 32'd1) begin
      timeout = 1'b1;
    end
    if (state_q == ST_STOP && fall_pulse) begin
      if (data_sync && parity_ok_q) frame_ok  = 1'b1;
      else                          frame_bad = 1'b1;
    end
  end

  assign push_en    = frame_ok && (shift_q != PS2_BREAK_CODE);
  assign push_entry = '{brk: break_pend_q, code: shift_q};

  // Frame FSM; the watchdog only runs while a frame is in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      parity_ok_q  <= 1'b0;
      break_pend_q <= 1'b0;
      wdog_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_bad | timeout;
      if (state_q == ST_IDLE || fall_pulse || timeout) wdog_q <= '0;
      else                                             wdog_q <= wdog_q + 32'd1;

      if (timeout) begin
        state_q      <= ST_IDLE;
        break_pend_q <= 1'b0;
      end else if (fall_pulse) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_sync) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            parity_ok_q <= ps2_odd_ok(shift_q, data_sync);
`else
            parity_ok_q <= 1'b1;
`endif
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (frame_ok) break_pend_q <= (shift_q == PS2_BREAK_CODE);
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fall_pulse && state_q == ST_DATA) shift_q <= {data_sync, shift_q[7:1]};
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_acc = push_en && (!full || pop);
  assign drop     = push_en && full && !pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_acc) wptr_d = wptr_q + 1'b1;
    if (pop)      rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= drop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wptr_q[AW-1:0]] <= push_entry;
  end

  assign head        = mem_q[rptr_q[AW-1:0]];
  assign o_valid     = !empty;
  assign o_code      = o_valid ? head.code : 8'h00;
  assign o_break     = o_valid ? head.brk : 1'b0;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: drives PS/2 frames and checks decoded keys against a queue model.
module tb_ps2_rx_decoder;

  localparam int SYNC  = 2;
  localparam int TMO   = 100;
  localparam int DEPTH = 4;
  localparam int H     = 10;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2c;
  logic       ps2d;
  logic       rdy;
  logic [7:0] o_code;
  logic       o_break;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overflow;

  always #5 clk = ~clk;

  ps2_rx_decoder #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (32'(TMO)),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2c),
    .i_ps2_data  (ps2d),
    .o_code      (o_code),
    .o_break     (o_break),
    .o_valid     (o_valid),
    .i_ready     (rdy),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  logic       bp_m = 1'b0;
  int         err_exp = 0, ovf_exp = 0, err_seen = 0, ovf_seen = 0;
  logic       hold = 1'b0;
  logic [7:0] hcode;
  logic       hbrk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what a complete frame means for the key queue, from the protocol rules alone.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
    if (!stp || (CHK && ($countones({b, par}) % 2 == 0))) begin
      err_exp++;
    end else if (b == 8'hF0) begin
      bp_m = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH) ovf_exp++;
      else                       exp_q.push_back({bp_m, b});
      bp_m = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic d);
    @(posedge clk); #1 ps2d = d;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit meas);
    int n;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    @(posedge clk); #1 ps2d = stp;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b0;
    model_frame(b, par, stp);
    n = 0;
    if (meas) begin
      do begin
        @(posedge clk); #1;
        n++;
      end while (!o_valid && n < 20);
      check("push_latency", 32'(n), 32'(SYNC + 1));
    end
    repeat (H - n) @(posedge clk);
    #1 ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  function automatic logic oddpar(input logic [7:0] b);
    return ($countones(b) % 2 == 0);
  endfunction

  task automatic settle_check(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_frame_err_count"}, 32'(err_seen), 32'(err_exp));
    check({tag, "_overflow_count"}, 32'(ovf_seen), 32'(ovf_exp));
    check({tag, "_valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic drain(input string tag);
    int n;
    @(posedge clk); #1 rdy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 rdy = 1'b0;
    check({tag, "_drain_done"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check({tag, "_empty_after_drain"}, 32'(o_valid), 32'd0);
  endtask

  // Compare process: every popped head must match the model queue; held heads must not move.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_frame_err) err_seen++;
        if (o_overflow)  ovf_seen++;
        if (hold) check("head_stable", {23'd0, o_valid, o_break, o_code}, {23'd0, 1'b1, hbrk, hcode});
        if (o_valid && rdy) begin
          if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
          else                   check("pop_entry", {23'd0, o_break, o_code}, {23'd0, exp_q.pop_front()});
        end
        hold  = o_valid && !rdy;
        hcode = o_code;
        hbrk  = o_break;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e0, o0;
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_code", 32'(o_code), 32'h0);
    check("rst_break", 32'(o_break), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_frame_err", 32'(o_frame_err), 32'h0);
    check("rst_overflow", 32'(o_overflow), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Plain make code with latency measurement.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("k1c_code", 32'(o_code), 32'h1C);
    check("k1c_break", 32'(o_break), 32'h0);
    settle_check("k1c");
    drain("k1c");

    // In-house keyboard break sequence F0 3E, both with parity 0.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3E, 1'b0, 1'b1, 1'b0);
    settle_check("brk3e");
    check("brk3e_code", 32'(o_code), 32'h3E);
    check("brk3e_break", 32'(o_break), CHK ? 32'h0 : 32'h1);
    drain("brk3e");

    // Bad stop bit.
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    settle_check("badstop");
    check("badstop_err_pulses", 32'(err_seen - e0), 32'd1);
    check("badstop_no_valid", 32'(o_valid), 32'h0);

    // Overflow: five keys into a four-entry FIFO with the consumer stalled.
    o0 = ovf_seen;
    send_frame(8'h15, oddpar(8'h15), 1'b1, 1'b0);
    send_frame(8'h1D, oddpar(8'h1D), 1'b1, 1'b0);
    send_frame(8'h24, oddpar(8'h24), 1'b1, 1'b0);
    send_frame(8'h2D, oddpar(8'h2D), 1'b1, 1'b0);
    send_frame(8'h2C, oddpar(8'h2C), 1'b1, 1'b0);
    settle_check("ovf");
    check("ovf_pulses", 32'(ovf_seen - o0), 32'd1);
    check("ovf_head", 32'(o_code), 32'h15);
    check("ovf_stored", 32'(exp_q.size()), 32'd4);
    drain("ovf");

    // Clock stalls after four data bits; next frame must still decode.
    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 40) @(posedge clk);
    err_exp++;
    bp_m = 1'b0;
    settle_check("tmo");
    check("tmo_err_pulses", 32'(err_seen - e0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    settle_check("tmo_next");
    check("tmo_next_code", 32'(o_code), 32'h1C);
    check("tmo_next_break", 32'(o_break), 32'h0);
    drain("tmo_next");

    // Properly-parity F0 prefix, then reset mid-frame; the prefix must be forgotten.
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("midrst_valid", 32'(o_valid), 32'h0);
    check("midrst_err", 32'(o_frame_err), 32'h0);
    bp_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(8'h3E, 1'b0, 1'b1, 1'b1);
    settle_check("midrst");
    check("midrst_code", 32'(o_code), 32'h3E);
    check("midrst_break", 32'(o_break), 32'h0);

    // Correct-parity F0 3E must report a release in either build.
    drain("midrst");
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3E, 1'b0, 1'b1, 1'b0);
    settle_check("brkok");
    check("brkok_code", 32'(o_code), 32'h3E);
    check("brkok_break", 32'(o_break), 32'h1);
    drain("brkok");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
